// File: rtl/lmsm_pkg.sv
// lmsm_pkg: shared widths and state encoding
// for the LM/SM memory-access sequencer.
package lmsm_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int MASK_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } lmsm_state_t;

endpackage

// File: rtl/lmsm_sequencer_lowest_set_bit_enc.sv
// lowest_set_bit_enc: 8-to-3 priority encoder, lowest index wins.
// Ports: In_mask (bit vector), Out_idx (lowest set index), Out_valid (any set).
module lowest_set_bit_enc
  import lmsm_pkg::*;
(
  input  logic [MASK_W-1:0] In_mask,
  output logic [IDX_W-1:0]  Out_idx,
  output logic              Out_valid
);

  // Scan high to low so the lowest set bit is written last.
  always_comb begin
    Out_idx = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (In_mask[i]) Out_idx = i[IDX_W-1:0];
    end
  end

  assign Out_valid = |In_mask;

endmodule

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: walks a register mask for LM/SM, one access per set bit.
// Ports: clock/reset, start+is_load+base+mask in, memory and register-file
// ports out (with combinational data pass-through), busy/done to control FSM.
module lmsm_sequencer
  import lmsm_pkg::*;
(
  input  logic              In_clock,
  input  logic              In_reset,
  input  logic              In_start,
  input  logic              In_is_load,
  input  logic [ADDR_W-1:0] In_base_addr,
  input  logic [MASK_W-1:0] In_reg_mask,
  input  logic [DATA_W-1:0] In_Mem_Read_data,
  input  logic [DATA_W-1:0] In_Rf_read_data,
  output logic              Out_Mem_Access_en,
  output logic              Out_Mem_Access_R_Wbar,
  output logic [ADDR_W-1:0] Out_Mem_Access_addr,
  output logic [DATA_W-1:0] Out_Mem_Write_data,
  output logic [IDX_W-1:0]  Out_Rf_addr,
  output logic              Out_Rf_write_en,
  output logic [DATA_W-1:0] Out_Rf_write_data,
  output logic              Out_busy,
  output logic              Out_done
);

  lmsm_state_t       r_state;
  lmsm_state_t       w_state_nxt;
  logic [MASK_W-1:0] r_mask;
  logic [ADDR_W-1:0] r_addr;
  logic              r_is_load;

  logic [IDX_W-1:0]  w_cur;
  logic              w_valid;
  logic [MASK_W-1:0] w_mask_nxt;
  logic              w_xfer;

  lowest_set_bit_enc u_enc (
    .In_mask   (r_mask),
    .Out_idx   (w_cur),
    .Out_valid (w_valid)
  );

  assign w_mask_nxt = r_mask & ~(MASK_W'(1) << w_cur);
  assign w_xfer     = (r_state == ST_XFER);

  always_ff @(posedge In_clock) begin
    if (In_reset) begin
      r_state   <= ST_IDLE;
      r_mask    <= '0;
      r_addr    <= '0;
      r_is_load <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (1'b1)
        (r_state == ST_IDLE): begin
          if (In_start) begin
            r_mask    <= In_reg_mask;
            r_addr    <= In_base_addr;
            r_is_load <= In_is_load;
          end
        end
        (r_state == ST_XFER): begin
          r_mask <= w_mask_nxt;
          r_addr <= r_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (In_start)
          w_state_nxt = (In_reg_mask == '0) ? ST_DONE : ST_XFER;
      end
      ST_XFER: begin
        if (w_mask_nxt == '0) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Out_Mem_Access_en     = 1'b0;
    Out_Mem_Access_R_Wbar = 1'b1;
    Out_Mem_Access_addr   = '0;
    Out_Mem_Write_data    = '0;
    Out_Rf_addr           = '0;
    Out_Rf_write_en       = 1'b0;
    Out_Rf_write_data     = '0;
    if (w_xfer && w_valid) begin
      Out_Mem_Access_en     = 1'b1;
      Out_Mem_Access_R_Wbar = r_is_load;
      Out_Mem_Access_addr   = r_addr;
      Out_Rf_addr           = w_cur;
      if (r_is_load) begin
        Out_Rf_write_en   = 1'b1;
        Out_Rf_write_data = In_Mem_Read_data;
      end else begin
        Out_Mem_Write_data = In_Rf_read_data;
      end
    end
  end

  assign Out_busy = (r_state != ST_IDLE);
  assign Out_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: directed bench with memory/RF models
// and an access scoreboard for lmsm_sequencer.
module tb_lmsm_sequencer;

  logic        In_clock = 1'b0;
  logic        In_reset;
  logic        In_start;
  logic        In_is_load;
  logic [15:0] In_base_addr;
  logic [7:0]  In_reg_mask;
  logic [15:0] In_Mem_Read_data;
  logic [15:0] In_Rf_read_data;
  logic        Out_Mem_Access_en;
  logic        Out_Mem_Access_R_Wbar;
  logic [15:0] Out_Mem_Access_addr;
  logic [15:0] Out_Mem_Write_data;
  logic [2:0]  Out_Rf_addr;
  logic        Out_Rf_write_en;
  logic [15:0] Out_Rf_write_data;
  logic        Out_busy;
  logic        Out_done;

  lmsm_sequencer dut (
    .In_clock              (In_clock),
    .In_reset              (In_reset),
    .In_start              (In_start),
    .In_is_load            (In_is_load),
    .In_base_addr          (In_base_addr),
    .In_reg_mask           (In_reg_mask),
    .In_Mem_Read_data      (In_Mem_Read_data),
    .In_Rf_read_data       (In_Rf_read_data),
    .Out_Mem_Access_en     (Out_Mem_Access_en),
    .Out_Mem_Access_R_Wbar (Out_Mem_Access_R_Wbar),
    .Out_Mem_Access_addr   (Out_Mem_Access_addr),
    .Out_Mem_Write_data    (Out_Mem_Write_data),
    .Out_Rf_addr           (Out_Rf_addr),
    .Out_Rf_write_en       (Out_Rf_write_en),
    .Out_Rf_write_data     (Out_Rf_write_data),
    .Out_busy              (Out_busy),
    .Out_done              (Out_done)
  );

  always #5 In_clock = ~In_clock;

  logic [15:0] mem [0:65535];
  logic [15:0] rf  [0:7];

  assign In_Mem_Read_data = mem[Out_Mem_Access_addr];
  assign In_Rf_read_data  = rf[Out_Rf_addr];

  // A processor held in reset commits nothing.
  always @(posedge In_clock) begin
    if (!In_reset) begin
      if (Out_Mem_Access_en && !Out_Mem_Access_R_Wbar)
        mem[Out_Mem_Access_addr] <= Out_Mem_Write_data;
      if (Out_Rf_write_en)
        rf[Out_Rf_addr] <= Out_Rf_write_data;
    end
  end

  typedef struct {
    logic [15:0] addr;
    logic [2:0]  idx;
    logic [15:0] data;
  } acc_t;

  acc_t q[$];
  bit   cur_ld;
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit done_e, input bit busy_e);
    bit   xf;
    acc_t e;
    xf = busy_e && !done_e;
    @(posedge In_clock);
    #1;
    chk("done", 16'(Out_done), 16'(done_e));
    chk("busy", 16'(Out_busy), 16'(busy_e));
    chk("en", 16'(Out_Mem_Access_en), 16'(xf));
    if (Out_Mem_Access_en) begin
      chk("sb_nonempty", 16'(q.size() != 0), 16'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("addr", Out_Mem_Access_addr, e.addr);
        chk("rwbar", 16'(Out_Mem_Access_R_Wbar), 16'(cur_ld));
        chk("rf_addr", 16'(Out_Rf_addr), 16'(e.idx));
        chk("rf_we", 16'(Out_Rf_write_en), 16'(cur_ld));
        if (cur_ld) chk("rf_wdata", Out_Rf_write_data, e.data);
        else        chk("mem_wdata", Out_Mem_Write_data, e.data);
      end
    end else begin
      chk("idle_rwbar", 16'(Out_Mem_Access_R_Wbar), 16'd1);
      chk("idle_addr", Out_Mem_Access_addr, 16'd0);
      chk("idle_wdata", Out_Mem_Write_data, 16'd0);
      chk("idle_rf_we", 16'(Out_Rf_write_en), 16'd0);
      chk("idle_rf_addr", 16'(Out_Rf_addr), 16'd0);
      chk("idle_rf_wdata", Out_Rf_write_data, 16'd0);
    end
  endtask

  task automatic run(input bit ld, input logic [15:0] base,
                     input logic [7:0] mask, input bit restart,
                     input int rst_c);
    int   n;
    acc_t e;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        e.addr = base + 16'(n);
        e.idx  = 3'(i);
        e.data = ld ? mem[e.addr] : rf[i];
        q.push_back(e);
        n++;
      end
    end
    cur_ld       = ld;
    In_is_load   = ld;
    In_base_addr = base;
    In_reg_mask  = mask;
    In_start     = 1'b1;
    for (int c = 1; c <= n + 2; c++) begin
      cyc(c == n + 1, c <= n + 1);
      In_start = restart && (c >= 2) && (c <= 5);
      if (c <= n) begin
        In_is_load   = 1'($urandom);
        In_base_addr = 16'($urandom);
        In_reg_mask  = 8'($urandom);
      end
      if (c == rst_c) begin
        In_reset = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        In_reset = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        q.delete();
        return;
      end
    end
    chk("sb_drained", 16'(q.size()), 16'd0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    for (int r = 0; r < 8; r++) rf[r] = 16'h0000;
    q.delete();
    In_reset     = 1'b1;
    In_start     = 1'b0;
    In_is_load   = 1'b0;
    In_base_addr = '0;
    In_reg_mask  = '0;
    cur_ld       = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    In_reset = 1'b0;
    cyc(1'b0, 1'b0);

    mem[16'h0004] = 16'hAAAA;
    mem[16'h0005] = 16'h5555;
    run(1'b1, 16'h0004, 8'b0000_0101, 1'b0, 0);
    chk("lm_r0", rf[0], 16'hAAAA);
    chk("lm_r2", rf[2], 16'h5555);
    chk("lm_r1", rf[1], 16'h0000);

    rf[1] = 16'h1234;
    rf[7] = 16'hBEEF;
    run(1'b0, 16'h0010, 8'b1000_0010, 1'b0, 0);
    chk("sm_m10", mem[16'h0010], 16'h1234);
    chk("sm_m11", mem[16'h0011], 16'hBEEF);

    run(1'b0, 16'h0040, 8'h00, 1'b0, 0);
    chk("m0_no_write", mem[16'h0040], 16'h0000);

    mem[16'hFFFF] = 16'h0F0F;
    mem[16'h0000] = 16'hF0F0;
    run(1'b1, 16'hFFFF, 8'b0000_0011, 1'b0, 0);
    chk("wrap_r0", rf[0], 16'h0F0F);
    chk("wrap_r1", rf[1], 16'hF0F0);

    for (int i = 0; i < 8; i++) mem[16'h0020 + 16'(i)] = 16'hC000 + 16'(i);
    run(1'b1, 16'h0020, 8'hFF, 1'b1, 0);
    for (int i = 0; i < 8; i++)
      chk("ff_rf", rf[i], 16'hC000 + 16'(i));

    run(1'b0, 16'h0100, 8'hFF, 1'b0, 3);
    chk("rst_m100", mem[16'h0100], 16'hC000);
    chk("rst_m101", mem[16'h0101], 16'hC001);
    chk("rst_m102", mem[16'h0102], 16'h0000);

    rf[3] = 16'h7777;
    run(1'b0, 16'h0200, 8'b0000_1000, 1'b0, 0);
    chk("post_rst_m200", mem[16'h0200], 16'h7777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
